// File: rtl/uart_pkg.sv
// Shared UART types and sizing constants used by the receiver,
// the RX FIFO and the future transmitter.
package uart_pkg;

   localparam int UART_DBIT        = 8;
   localparam int UART_FIFO_ADDR_W = 4;

   typedef logic [UART_DBIT-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// RX FIFO bus: push side (wr/w_data), pop side (rd/r_data) and status.
// master = receiver/consumer side, slave = the FIFO.
// Optional UART_RX_FIFO_OVF_EN adds ovf / ovf_clr.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int DBIT   = UART_DBIT,
   parameter int ADDR_W = UART_FIFO_ADDR_W
);

   logic              wr;
   logic [DBIT-1:0]   w_data;
   logic              rd;
   logic [DBIT-1:0]   r_data;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
`ifdef UART_RX_FIFO_OVF_EN
   logic              ovf;
   logic              ovf_clr;

   modport master (
      output wr,
      output w_data,
      output rd,
      output ovf_clr,
      input  r_data,
      input  empty,
      input  full,
      input  count,
      input  ovf
   );

   modport slave (
      input  wr,
      input  w_data,
      input  rd,
      input  ovf_clr,
      output r_data,
      output empty,
      output full,
      output count,
      output ovf
   );
`else
   modport master (
      output wr,
      output w_data,
      output rd,
      input  r_data,
      input  empty,
      input  full,
      input  count
   );

   modport slave (
      input  wr,
      input  w_data,
      input  rd,
      output r_data,
      output empty,
      output full,
      output count
   );
`endif

endinterface

// File: rtl/uart_fifo_ctrl.sv
// FIFO control: pointers, occupancy count, empty/full flags, push/pop
// accept and (with UART_RX_FIFO_OVF_EN) the sticky overrun flag.
module uart_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int ADDR_W = UART_FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wr,
   input  logic              i_rd,
`ifdef UART_RX_FIFO_OVF_EN
   input  logic              i_ovf_clr,
   output logic              o_ovf,
`endif
   output logic              o_push,
   output logic [ADDR_W-1:0] o_w_addr,
   output logic [ADDR_W-1:0] o_r_addr,
   output logic              o_empty,
   output logic              o_full,
   output logic [ADDR_W:0]   o_count
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] r_w_ptr;
   logic [ADDR_W-1:0] r_r_ptr;
   logic [ADDR_W:0]   r_count;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == DEPTH);

   // A pop in the same cycle frees the slot, so a push into a full
   // queue is still taken when rd is high.
   assign w_push = i_wr & (~w_full | i_rd);
   assign w_pop  = i_rd & ~w_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_w_ptr <= '0;
         r_r_ptr <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_w_ptr <= r_w_ptr + 1'b1;
         if (w_pop)
            r_r_ptr <= r_r_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef UART_RX_FIFO_OVF_EN
   logic w_drop;
   logic r_ovf;

   assign w_drop = i_wr & w_full & ~i_rd;

   // Set has priority over clear so no overrun is ever lost.
   always_ff @(posedge clk) begin
      if (!reset)
         r_ovf <= 1'b0;
      else if (w_drop)
         r_ovf <= 1'b1;
      else if (i_ovf_clr)
         r_ovf <= 1'b0;
   end

   assign o_ovf = r_ovf;
`endif

   assign o_push   = w_push;
   assign o_w_addr = r_w_ptr;
   assign o_r_addr = r_r_ptr;
   assign o_empty  = w_empty;
   assign o_full   = w_full;
   assign o_count  = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO, first-word-fall-through, 2^ADDR_W deep.
// Ports: clk, reset (sync, active-low), bus (uart_rx_fifo_if.slave).
// Define UART_RX_FIFO_OVF_EN to get the sticky ovf flag and ovf_clr.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DBIT   = UART_DBIT,
   parameter int ADDR_W = UART_FIFO_ADDR_W
) (
   input  logic           clk,
   input  logic           reset,
   uart_rx_fifo_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DBIT-1:0]   r_mem [DEPTH];

   logic              w_push;
   logic [ADDR_W-1:0] w_w_addr;
   logic [ADDR_W-1:0] w_r_addr;
   logic              w_empty;
   logic              w_full;
   logic [ADDR_W:0]   w_count;

   uart_fifo_ctrl #(
      .ADDR_W    (ADDR_W)
   ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .i_wr      (bus.wr),
      .i_rd      (bus.rd),
`ifdef UART_RX_FIFO_OVF_EN
      .i_ovf_clr (bus.ovf_clr),
      .o_ovf     (bus.ovf),
`endif
      .o_push    (w_push),
      .o_w_addr  (w_w_addr),
      .o_r_addr  (w_r_addr),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_count   (w_count)
   );

   // Storage is deliberately not reset; stale entries are masked
   // by the empty gate on r_data.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[w_w_addr] <= bus.w_data;
   end

   assign bus.r_data = w_empty ? '0 : r_mem[w_r_addr];
   assign bus.empty  = w_empty;
   assign bus.full   = w_full;
   assign bus.count  = w_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed pushes/pops,
// a negedge monitor checks every accepted pop against the queue.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(
      .DBIT   (UART_DBIT),
      .ADDR_W (UART_FIFO_ADDR_W)
   ) u_if ();

   uart_rx_fifo #(
      .DBIT   (UART_DBIT),
      .ADDR_W (UART_FIFO_ADDR_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   uart_byte_t sb[$];
   uart_byte_t m_exp;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock of stimulus; acc says whether the byte must be kept.
   task automatic cyc(input logic wr, input uart_byte_t d,
                      input logic rd, input logic acc);
      u_if.wr     = wr;
      u_if.w_data = d;
      u_if.rd     = rd;
      if (wr && acc)
         sb.push_back(d);
      @(posedge clk);
      #1;
      u_if.wr     = 1'b0;
      u_if.w_data = '0;
      u_if.rd     = 1'b0;
   endtask

   task automatic push(input uart_byte_t d);
      cyc(1'b1, d, 1'b0, 1'b1);
   endtask

   task automatic pop();
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   // Monitor: a pop is taken at the next edge when rd=1 and not empty.
   always @(negedge clk) begin
      if (reset && u_if.rd && !u_if.empty) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL pop_data: got %0h expected no pop",
                     u_if.r_data);
         end else begin
            m_exp = sb.pop_front();
            if (u_if.r_data !== m_exp) begin
               n_bad++;
               $display("FAIL pop_data: got %0h expected %0h",
                        u_if.r_data, m_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      u_if.wr     = 1'b0;
      u_if.w_data = '0;
      u_if.rd     = 1'b0;
`ifdef UART_RX_FIFO_OVF_EN
      u_if.ovf_clr = 1'b0;
`endif
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // reset state and rd while empty
      chk("rst_empty", u_if.empty, 1);
      chk("rst_full", u_if.full, 0);
      chk("rst_count", u_if.count, 0);
      chk("rst_rdata", u_if.r_data, 8'h00);
`ifdef UART_RX_FIFO_OVF_EN
      chk("rst_ovf", u_if.ovf, 0);
`endif
      pop();
      chk("idle_rd_count", u_if.count, 0);
      chk("idle_rd_empty", u_if.empty, 1);

      // two pushes, two pops
      push(8'hA5);
      chk("fwft_rdata", u_if.r_data, 8'hA5);
      chk("fwft_empty", u_if.empty, 0);
      push(8'h3C);
      chk("two_rdata", u_if.r_data, 8'hA5);
      chk("two_count", u_if.count, 2);
      pop();
      chk("pop1_rdata", u_if.r_data, 8'h3C);
      chk("pop1_count", u_if.count, 1);
      pop();
      chk("pop2_empty", u_if.empty, 1);
      chk("pop2_rdata", u_if.r_data, 8'h00);

      // wr+rd while empty: byte stored, pop ignored
      cyc(1'b1, 8'h77, 1'b1, 1'b1);
      chk("wr_rd_empty_cnt", u_if.count, 1);
      chk("wr_rd_empty_dat", u_if.r_data, 8'h77);
      pop();

      // fill, overrun, drain
      for (int i = 0; i < 16; i++)
         push(uart_byte_t'(i));
      chk("fill_full", u_if.full, 1);
      chk("fill_count", u_if.count, 16);
      chk("fill_head", u_if.r_data, 8'h00);
      cyc(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("drop_count", u_if.count, 16);
      chk("drop_head", u_if.r_data, 8'h00);
`ifdef UART_RX_FIFO_OVF_EN
      chk("ovf_set", u_if.ovf, 1);
`endif
      for (int i = 0; i < 16; i++)
         pop();
      chk("drain_empty", u_if.empty, 1);
      chk("drain_count", u_if.count, 0);
`ifdef UART_RX_FIFO_OVF_EN
      chk("ovf_sticky", u_if.ovf, 1);
      u_if.ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      u_if.ovf_clr = 1'b0;
      chk("ovf_clr", u_if.ovf, 0);
`endif

      // wr+rd while full
      for (int i = 0; i < 16; i++)
         push(uart_byte_t'(8'h10 + i));
      chk("refill_full", u_if.full, 1);
      cyc(1'b1, 8'h55, 1'b1, 1'b1);
      chk("both_full_cnt", u_if.count, 16);
      chk("both_full_head", u_if.r_data, 8'h11);
      chk("both_full_flag", u_if.full, 1);
`ifdef UART_RX_FIFO_OVF_EN
      chk("both_full_ovf", u_if.ovf, 0);
`endif
      for (int i = 0; i < 15; i++)
         pop();
      chk("last_is_55", u_if.r_data, 8'h55);
      pop();
      chk("both_drain_emp", u_if.empty, 1);

      // wrap-around, count held in 1..2
      push(8'h40);
      for (int i = 0; i < 40; i++) begin
         case (i % 4)
            0: cyc(1'b1, uart_byte_t'(8'h80 + i), 1'b0, 1'b1);
            1: cyc(1'b1, uart_byte_t'(8'h80 + i), 1'b1, 1'b1);
            2: cyc(1'b0, 8'h00, 1'b1, 1'b0);
            default: cyc(1'b1, uart_byte_t'(8'h80 + i), 1'b1, 1'b1);
         endcase
      end
      chk("wrap_count", u_if.count, 1);
      chk("wrap_head", u_if.r_data, 8'h80 + 39);
      pop();
      chk("wrap_empty", u_if.empty, 1);

      // reset mid-burst with count 7
      for (int i = 0; i < 7; i++)
         push(uart_byte_t'(8'hC0 + i));
      chk("pre_rst_count", u_if.count, 7);
      reset       = 1'b0;
      u_if.wr     = 1'b1;
      u_if.w_data = 8'h99;
      @(posedge clk);
      #1;
      reset   = 1'b1;
      u_if.wr = 1'b0;
      sb.delete();
      chk("mid_rst_count", u_if.count, 0);
      chk("mid_rst_empty", u_if.empty, 1);
      chk("mid_rst_rdata", u_if.r_data, 8'h00);
      chk("mid_rst_full", u_if.full, 0);
      push(8'h81);
      chk("post_rst_rdata", u_if.r_data, 8'h81);
      chk("post_rst_count", u_if.count, 1);
      pop();

      repeat (2) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
